traffic_display: RTL
====================

Name: traffic_display

Overview:
- Downstream consumer of the phase/countdown counter: takes its 2-bit phase code and 4-bit remaining count and drives the board outputs.
- Drives the three traffic lamps and a 2-digit time-multiplexed seven-segment readout of the remaining seconds.
- Runs on the fast board clock and resynchronises the counter outputs, which change on the slow divided clock.

Parameters:
- SCAN_DIV, 50000, board clocks per digit-scan slot; the active digit toggles every SCAN_DIV clocks. Minimum 2.
- BLINK_DIV, 12500000, board clocks per blink half-period. Used only with BLINK_EN.

Ports:
- clock  in  1  board clock
- reset  in  1  synchronous, active-high reset
- state  in  2  phase code from the counter: 0 = green, 1 = yellow, 2 = red, 3 = illegal
- count  in  4  remaining seconds from the counter, 0..15
- light  out 3  lamp drives {red, yellow, green}, active-high
- seg    out 7  segments {g,f,e,d,c,b,a}, active-low
- an     out 2  digit enables {tens, ones}, active-low; exactly one bit low outside reset

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All registers update on the rising edge of clock only.
- Reset values:
  - light = 3'b000
  - seg = 7'h7F (all segments off)
  - an = 2'b11
  - synchroniser and held registers = 0
  - scan counter = 0, active digit = ones
- Input capture:
  - state and count pass through a two-flop synchroniser, as a 6-bit bundle.
  - A stability stage compares the synchronised bundle with its previous-cycle copy.
  - The held registers (h_state, h_count) load only when the two are equal.
  - Latency from an input change to the held registers: 3 clocks when stable. A bundle changing every cycle never loads.
- Lamp decode (registered from the held values, 1 clock after the held update):
  - h_state 0 -> 001 (green)
  - h_state 1 -> 010 (yellow)
  - h_state 2 -> 100 (red)
  - h_state 3 -> 000 (all off)
- Digit decode:
  - tens = 1 if h_count >= 10, else 0; ones = h_count - 10*tens.
  - No divider is used: a single compare and subtract.
  - Leading zero blanking: when tens = 0 the tens digit shows blank (7'h7F).
  - h_state 3 overrides the count: both digits show '-', i.e. seg = 7'h3F (only g lit).
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 and wraps to 0.
  - On wrap the active digit toggles.
  - an and seg are registered together, so no cycle shows one digit's segments on the other digit's enable.
  - Active digit ones: an = 2'b10. Active digit tens: an = 2'b01.
- Boundary conditions:
  - h_count changes mid-slot: the new value appears on the next clock for the active digit; the slot is not restarted.
  - count = 0 passes through and shows "0" on the ones digit with the tens digit blank.
  - reset asserted mid-scan: all outputs return to their reset values on the next edge, and scanning restarts on ones.
- Segment encoding, active-low, digits 0..9:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex)

Optional Feature:
- Macro: TRAFFIC_DISPLAY_BLINK_EN
- Defined:
  - A free-running blink counter toggles a blink phase every BLINK_DIV clocks. Blink counter and phase reset to 0.
  - When h_state is 0..2 and h_count <= 3, the active lamp is gated off while the blink phase is 1. Digits are unaffected.
  - The blink phase keeps running across phase changes and is not restarted.
- Undefined: the lamps are steady, and the blink counter and BLINK_DIV produce no logic.

Test Plan:
- reset high 2 clocks with SCAN_DIV = 4 -> light = 000, seg = 7F, an = 11; after release the first an = 10 and it toggles every 4 clocks.
- state = 0, count = 15 held -> within 4 clocks light = 001; ones slot seg = 12 ("5"), tens slot seg = 79 ("1").
- state = 1, count = 5 -> light = 010; ones seg = 12, tens seg = 7F (blanked).
- state = 3, count = 9 -> light = 000; both slots seg = 3F.
- count toggled 7/8 every cycle for 10 clocks, then held at 8 -> the held value stays at its prior setting during toggling and becomes 8 exactly 3 clocks after the hold.
- BLINK_EN, BLINK_DIV = 3, state = 2, count = 2 -> light alternates 100/000 every 3 clocks; count = 4 -> steady 100.

Source files
------------

// File: rtl/traffic_display.sv
// traffic_display: drives the three lamps and a 2-digit multiplexed seven-segment readout
// from the counter's phase/count. Define TRAFFIC_DISPLAY_BLINK_EN to blink the lamp near phase end.
module traffic_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic [3:0] count,
    output logic [2:0] light,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int            SW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    localparam logic [1:0] ST_GREEN   = 2'd0;
    localparam logic [1:0] ST_YELLOW  = 2'd1;
    localparam logic [1:0] ST_RED     = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    if (SCAN_DIV < 2) begin : gBadScanDiv
        $error("traffic_display: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 1) begin : gBadBlinkDiv
        $error("traffic_display: BLINK_DIV must be at least 1");
    end

    logic [5:0]    r_sync1;
    logic [5:0]    r_sync2;
    logic [1:0]    r_hState;
    logic [3:0]    r_hCount;
    logic [SW-1:0] r_scanCnt;
    logic          r_digitTens;
    logic [2:0]    r_light;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_stable;
    logic          w_tens;
    logic [3:0]    w_ones;
    logic [6:0]    w_tensSeg;
    logic [6:0]    w_onesSeg;
    logic [2:0]    w_lamp;
    logic          w_blinkOff;

    function automatic logic [6:0] segOf(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // The held copy only follows the synchroniser once two consecutive samples agree,
    // so a bundle caught mid-change on the slow clock never reaches the display.
    assign w_stable = (r_sync1 == r_sync2);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_hState <= '0;
            r_hCount <= '0;
        end else begin
            r_sync1 <= {state, count};
            r_sync2 <= r_sync1;
            if (w_stable) begin
                r_hState <= r_sync1[5:4];
                r_hCount <= r_sync1[3:0];
            end
        end
    end

    assign w_tens    = (r_hCount >= 4'd10);
    assign w_ones    = w_tens ? (r_hCount - 4'd10) : r_hCount;
    assign w_onesSeg = (r_hState == ST_ILLEGAL) ? SEG_DASH : segOf(w_ones);
    assign w_tensSeg = (r_hState == ST_ILLEGAL) ? SEG_DASH :
                       (w_tens ? segOf(4'd1) : SEG_BLANK);

    always_comb begin
        w_lamp = 3'b000;
        case (r_hState)
            ST_GREEN:  w_lamp = 3'b001;
            ST_YELLOW: w_lamp = 3'b010;
            ST_RED:    w_lamp = 3'b100;
            default:   w_lamp = 3'b000;
        endcase
    end

`ifdef TRAFFIC_DISPLAY_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blinkCnt;
    logic          r_blinkPhase;

    // Free-running so the blink cadence is not disturbed by phase changes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + BW'(1);
        end
    end

    assign w_blinkOff = r_blinkPhase && (r_hState != ST_ILLEGAL) && (r_hCount <= 4'd3);
`else
    assign w_blinkOff = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_scanCnt   <= '0;
            r_digitTens <= 1'b0;
        end else if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt   <= '0;
            r_digitTens <= ~r_digitTens;
        end else begin
            r_scanCnt <= r_scanCnt + SW'(1);
        end
    end

    // Enable and segments are registered in the same edge so a digit never shows
    // the other digit's pattern, even for one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_light <= 3'b000;
            r_seg   <= SEG_BLANK;
            r_an    <= 2'b11;
        end else begin
            r_light <= w_lamp & ~{3{w_blinkOff}};
            r_an    <= r_digitTens ? 2'b01 : 2'b10;
            r_seg   <= r_digitTens ? w_tensSeg : w_onesSeg;
        end
    end

    assign light = r_light;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule
